// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store unit.
// Sizes, FSM states, byte-enable / store-lane builders and the alignment rule.
package lsu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ    = 2'b01,
        WAIT_R = 2'b10
    } state_e;

    function automatic logic [3:0] be_for(size_e size, logic [1:0] a);
        case (size)
            SZ_B:    return 4'b0001 << a;
            SZ_H:    return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] lane_wdata(size_e size, logic [DATA_W-1:0] d);
        case (size)
            SZ_B:    return {4{d[7:0]}};
            SZ_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // The reserved size code is always rejected, regardless of address.
    function automatic logic is_misaligned(size_e size, logic [1:0] a);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return a[0];
            SZ_W:    return a != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory port: req/gnt request channel plus rvalid/rdata response channel.
interface lsu_dmem_if #(
    parameter int ADDR_W = 32
) ();
    import lsu_pkg::*;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/lsu_load_align.sv
// Load lane selection and sign/zero extension of the returned memory word.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        off_i,
    input  size_e             size_i,
    input  logic              uns_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] lane;

    assign lane = rdata_i >> {off_i, 3'b000};

    always_comb begin
        data_o = lane;
        case (size_i)
            SZ_B:    data_o = uns_i ? {24'b0, lane[7:0]}   : {{24{lane[7]}}, lane[7:0]};
            SZ_H:    data_o = uns_i ? {16'b0, lane[15:0]}  : {{16{lane[15]}}, lane[15:0]};
            default: data_o = lane;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: one blocking access at a time over a req/gnt +
// rvalid memory port, with misalignment rejection and a bounded wait timeout.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic              ex_mem_read_i,
    input  logic              ex_mem_write_i,
    input  logic [1:0]        ex_size_i,
    input  logic              ex_unsigned_i,
    input  logic [ADDR_W-1:0] ex_addr_i,
    input  logic [DATA_W-1:0] ex_store_data_i,
    input  logic [4:0]        ex_rd_i,
    lsu_dmem_if.master        dmem,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              store_done_o,
    output logic              misalign_o,
    output logic              timeout_o
);

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    state_e            state_q;
    logic              ex_ready_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] wdata_q;
    size_e             size_q;
    logic              uns_q;
    logic [1:0]        off_q;
    logic [4:0]        rd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              wb_valid_q;
    logic [4:0]        wb_rd_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              store_done_q;
    logic              misalign_q;
    logic              timeout_q;

    size_e             ex_size;
    logic              ex_is_mem;
    logic [DATA_W-1:0] load_data;

    assign ex_size   = size_e'(ex_size_i);
    assign ex_is_mem = ex_mem_read_i | ex_mem_write_i;

    lsu_load_align u_align (
        .rdata_i (dmem.rdata),
        .off_i   (off_q),
        .size_i  (size_q),
        .uns_i   (uns_q),
        .data_o  (load_data)
    );

    // Status pulses default low each cycle; only the transition that owns them raises one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ex_ready_q   <= 1'b1;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            size_q       <= SZ_B;
            uns_q        <= 1'b0;
            off_q        <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            store_done_q <= 1'b0;
            misalign_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            wb_valid_q   <= 1'b0;
            store_done_q <= 1'b0;
            misalign_q   <= 1'b0;
            timeout_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ex_valid_i && ex_is_mem) begin
                        if (is_misaligned(ex_size, ex_addr_i[1:0])) begin
                            misalign_q <= 1'b1;
                        end else begin
                            state_q    <= REQ;
                            ex_ready_q <= 1'b0;
                            req_q      <= 1'b1;
                            we_q       <= ex_mem_write_i;
                            addr_q     <= {ex_addr_i[ADDR_W-1:2], 2'b00};
                            be_q       <= be_for(ex_size, ex_addr_i[1:0]);
                            wdata_q    <= lane_wdata(ex_size, ex_store_data_i);
                            size_q     <= ex_size;
                            uns_q      <= ex_unsigned_i;
                            off_q      <= ex_addr_i[1:0];
                            rd_q       <= ex_rd_i;
                            cnt_q      <= '0;
                        end
                    end
                end
                REQ: begin
                    if (dmem.gnt) begin
                        req_q <= 1'b0;
                        cnt_q <= '0;
                        if (we_q) begin
                            store_done_q <= 1'b1;
                            state_q      <= IDLE;
                            ex_ready_q   <= 1'b1;
                        end else begin
                            state_q <= WAIT_R;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        req_q      <= 1'b0;
                        timeout_q  <= 1'b1;
                        state_q    <= IDLE;
                        ex_ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WAIT_R: begin
                    if (dmem.rvalid) begin
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= rd_q;
                        wb_data_q  <= load_data;
                        state_q    <= IDLE;
                        ex_ready_q <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        timeout_q  <= 1'b1;
                        state_q    <= IDLE;
                        ex_ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    ex_ready_q <= 1'b1;
                    req_q      <= 1'b0;
                end
            endcase
        end
    end

    assign ex_ready_o   = ex_ready_q;
    assign dmem.req     = req_q;
    assign dmem.we      = we_q;
    assign dmem.addr    = addr_q;
    assign dmem.be      = be_q;
    assign dmem.wdata   = wdata_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign store_done_o = store_done_q;
    assign misalign_o   = misalign_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, misalignment, stalls, timeout, reset.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ex_valid, ex_ready, ex_mem_read, ex_mem_write, ex_unsigned;
    logic [1:0]  ex_size;
    logic [31:0] ex_addr, ex_store_data;
    logic [4:0]  ex_rd, wb_rd;
    logic        wb_valid, store_done, misalign, timeout;
    logic [31:0] wb_data;
    int          pass_cnt;
    int          total_cnt;

    lsu_dmem_if #(.ADDR_W(32)) dmem_if ();

    load_store_unit #(.ADDR_W(32), .MAX_WAIT(15)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_valid_i      (ex_valid),
        .ex_ready_o      (ex_ready),
        .ex_mem_read_i   (ex_mem_read),
        .ex_mem_write_i  (ex_mem_write),
        .ex_size_i       (ex_size),
        .ex_unsigned_i   (ex_unsigned),
        .ex_addr_i       (ex_addr),
        .ex_store_data_i (ex_store_data),
        .ex_rd_i         (ex_rd),
        .dmem            (dmem_if),
        .wb_valid_o      (wb_valid),
        .wb_rd_o         (wb_rd),
        .wb_data_o       (wb_data),
        .store_done_o    (store_done),
        .misalign_o      (misalign),
        .timeout_o       (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic rd_op, input logic wr_op, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] rd);
        ex_valid      = 1'b1;
        ex_mem_read   = rd_op;
        ex_mem_write  = wr_op;
        ex_size       = sz;
        ex_unsigned   = uns;
        ex_addr       = addr;
        ex_store_data = data;
        ex_rd         = rd;
        tick();
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total_cnt++; if (ex_ready !== 1'b1) $display("FAIL reset_ex_ready got %b want 1", ex_ready); else pass_cnt++;
        total_cnt++; if (dmem_if.req !== 1'b0) $display("FAIL reset_req got %b want 0", dmem_if.req); else pass_cnt++;
        total_cnt++; if ({wb_valid, store_done, misalign, timeout} !== 4'b0000)
            $display("FAIL reset_pulses got %b want 0000", {wb_valid, store_done, misalign, timeout}); else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ignore();
        send(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0044, 32'h0, 5'd1);
        total_cnt++; if (dmem_if.req !== 1'b0 || ex_ready !== 1'b1 || misalign !== 1'b0)
            $display("FAIL nop_ignored got req=%b rdy=%b mis=%b want 0 1 0", dmem_if.req, ex_ready, misalign); else pass_cnt++;
    endtask

    task automatic test_lw();
        send(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 5'd5);
        total_cnt++; if (dmem_if.req !== 1'b1 || dmem_if.we !== 1'b0 || ex_ready !== 1'b0)
            $display("FAIL lw_req got req=%b we=%b rdy=%b want 1 0 0", dmem_if.req, dmem_if.we, ex_ready); else pass_cnt++;
        total_cnt++; if (dmem_if.addr !== 32'h10 || dmem_if.be !== 4'hF)
            $display("FAIL lw_addr_be got %h %b want 00000010 1111", dmem_if.addr, dmem_if.be); else pass_cnt++;
        dmem_if.gnt = 1'b1;
        tick();
        dmem_if.gnt    = 1'b0;
        dmem_if.rvalid = 1'b1;
        dmem_if.rdata  = 32'hDEAD_BEEF;
        total_cnt++; if (dmem_if.req !== 1'b0 || wb_valid !== 1'b0)
            $display("FAIL lw_t2 got req=%b wbv=%b want 0 0", dmem_if.req, wb_valid); else pass_cnt++;
        tick();
        dmem_if.rvalid = 1'b0;
        total_cnt++; if (wb_valid !== 1'b1 || wb_data !== 32'hDEAD_BEEF || wb_rd !== 5'd5)
            $display("FAIL lw_wb got v=%b d=%h rd=%0d want 1 deadbeef 5", wb_valid, wb_data, wb_rd); else pass_cnt++;
        total_cnt++; if (ex_ready !== 1'b1) $display("FAIL lw_ready_t3 got %b want 1", ex_ready); else pass_cnt++;
        tick();
        total_cnt++; if (wb_valid !== 1'b0) $display("FAIL lw_wb_pulse got %b want 0", wb_valid); else pass_cnt++;
    endtask

    task automatic test_lb();
        logic [31:0] exp;
        for (int u = 0; u < 2; u++) begin
            exp = (u == 1) ? 32'h0000_0080 : 32'hFFFF_FF80;
            send(1'b1, 1'b0, 2'b00, u[0], 32'h0000_0013, 32'h0, 5'd9);
            total_cnt++; if (dmem_if.be !== 4'b1000 || dmem_if.addr !== 32'h10)
                $display("FAIL lb_be u=%0d got %b %h want 1000 00000010", u, dmem_if.be, dmem_if.addr); else pass_cnt++;
            dmem_if.gnt = 1'b1;
            tick();
            dmem_if.gnt    = 1'b0;
            dmem_if.rvalid = 1'b1;
            dmem_if.rdata  = 32'h8000_0000;
            tick();
            dmem_if.rvalid = 1'b0;
            total_cnt++; if (wb_valid !== 1'b1 || wb_data !== exp)
                $display("FAIL lb_data u=%0d got v=%b d=%h want 1 %h", u, wb_valid, wb_data, exp); else pass_cnt++;
        end
        send(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0, 5'd3);
        dmem_if.gnt = 1'b1;
        tick();
        dmem_if.gnt    = 1'b0;
        dmem_if.rvalid = 1'b1;
        dmem_if.rdata  = 32'h9234_5678;
        tick();
        dmem_if.rvalid = 1'b0;
        total_cnt++; if (wb_data !== 32'hFFFF_9234)
            $display("FAIL lh_hi_data got %h want ffff9234", wb_data); else pass_cnt++;
    endtask

    task automatic test_store();
        send(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h1234_ABCD, 5'd0);
        total_cnt++; if (dmem_if.req !== 1'b1 || dmem_if.we !== 1'b1 || dmem_if.be !== 4'b1100)
            $display("FAIL sh_req got req=%b we=%b be=%b want 1 1 1100", dmem_if.req, dmem_if.we, dmem_if.be); else pass_cnt++;
        total_cnt++; if (dmem_if.wdata !== 32'hABCD_ABCD || dmem_if.addr !== 32'h20)
            $display("FAIL sh_wdata got %h %h want abcdabcd 00000020", dmem_if.wdata, dmem_if.addr); else pass_cnt++;
        dmem_if.gnt = 1'b1;
        tick();
        dmem_if.gnt = 1'b0;
        total_cnt++; if (store_done !== 1'b1 || wb_valid !== 1'b0 || dmem_if.req !== 1'b0 || ex_ready !== 1'b1)
            $display("FAIL sh_done got sd=%b wbv=%b req=%b rdy=%b want 1 0 0 1", store_done, wb_valid, dmem_if.req, ex_ready); else pass_cnt++;
        tick();
        total_cnt++; if (store_done !== 1'b0 || wb_valid !== 1'b0)
            $display("FAIL sh_pulse got sd=%b wbv=%b want 0 0", store_done, wb_valid); else pass_cnt++;
        send(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0031, 32'h5566_77EF, 5'd0);
        total_cnt++; if (dmem_if.we !== 1'b1 || dmem_if.be !== 4'b0010 || dmem_if.wdata !== 32'hEFEF_EFEF)
            $display("FAIL sb_lanes got we=%b be=%b wd=%h want 1 0010 efefefef", dmem_if.we, dmem_if.be, dmem_if.wdata); else pass_cnt++;
        dmem_if.gnt = 1'b1;
        tick();
        dmem_if.gnt = 1'b0;
        total_cnt++; if (store_done !== 1'b1) $display("FAIL sb_done got %b want 1", store_done); else pass_cnt++;
        tick();
    endtask

    task automatic test_misalign();
        logic [1:0]  sz [3];
        logic [31:0] ad [3];
        sz[0] = 2'b10; ad[0] = 32'h06;
        sz[1] = 2'b01; ad[1] = 32'h01;
        sz[2] = 2'b11; ad[2] = 32'h00;
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 1'b0, sz[i], 1'b0, ad[i], 32'h0, 5'd7);
            total_cnt++; if (misalign !== 1'b1 || dmem_if.req !== 1'b0 || ex_ready !== 1'b1)
                $display("FAIL misalign_%0d got mis=%b req=%b rdy=%b want 1 0 1", i, misalign, dmem_if.req, ex_ready); else pass_cnt++;
            tick();
            total_cnt++; if (misalign !== 1'b0 || dmem_if.req !== 1'b0 || ex_ready !== 1'b1)
                $display("FAIL misalign_after_%0d got mis=%b req=%b rdy=%b want 0 0 1", i, misalign, dmem_if.req, ex_ready); else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        send(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 5'd12);
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (dmem_if.req !== 1'b1 || dmem_if.addr !== 32'h40 || dmem_if.be !== 4'hF)
                $display("FAIL stall_hold_%0d got req=%b a=%h be=%b want 1 00000040 1111", i, dmem_if.req, dmem_if.addr, dmem_if.be); else pass_cnt++;
            if (i == 3) dmem_if.gnt = 1'b1;
            tick();
        end
        dmem_if.gnt    = 1'b0;
        dmem_if.rvalid = 1'b1;
        dmem_if.rdata  = 32'h0102_0304;
        tick();
        dmem_if.rvalid = 1'b0;
        total_cnt++; if (wb_valid !== 1'b1 || wb_data !== 32'h0102_0304 || wb_rd !== 5'd12)
            $display("FAIL stall_wb got v=%b d=%h rd=%0d want 1 01020304 12", wb_valid, wb_data, wb_rd); else pass_cnt++;
        tick();
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        send(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0050, 32'h0, 5'd4);
        for (int i = 0; i < 15; i++) begin
            if (dmem_if.req !== 1'b1 || timeout !== 1'b0) bad++;
            tick();
        end
        total_cnt++; if (bad != 0) $display("FAIL timeout_req_window got %0d bad cycles want 0", bad); else pass_cnt++;
        total_cnt++; if (timeout !== 1'b1 || dmem_if.req !== 1'b0 || ex_ready !== 1'b1 || wb_valid !== 1'b0)
            $display("FAIL timeout_pulse got to=%b req=%b rdy=%b wbv=%b want 1 0 1 0", timeout, dmem_if.req, ex_ready, wb_valid); else pass_cnt++;
        tick();
        total_cnt++; if (timeout !== 1'b0 || wb_valid !== 1'b0)
            $display("FAIL timeout_after got to=%b wbv=%b want 0 0", timeout, wb_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        send(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0060, 32'h0, 5'd8);
        rst_n = 1'b0;
        #1;
        total_cnt++; if (dmem_if.req !== 1'b0 || ex_ready !== 1'b1)
            $display("FAIL rst_req_async got req=%b rdy=%b want 0 1", dmem_if.req, ex_ready); else pass_cnt++;
        #1 rst_n = 1'b1;
        tick();
        send(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0064, 32'h0, 5'd8);
        dmem_if.gnt = 1'b1;
        tick();
        dmem_if.gnt = 1'b0;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        dmem_if.rvalid = 1'b1;
        dmem_if.rdata  = 32'hCAFE_F00D;
        tick();
        dmem_if.rvalid = 1'b0;
        total_cnt++; if (wb_valid !== 1'b0 || wb_data !== 32'h0 || wb_rd !== 5'd0)
            $display("FAIL rst_late_rvalid got v=%b d=%h rd=%0d want 0 00000000 0", wb_valid, wb_data, wb_rd); else pass_cnt++;
        total_cnt++; if (ex_ready !== 1'b1 || dmem_if.req !== 1'b0 || timeout !== 1'b0 || store_done !== 1'b0)
            $display("FAIL rst_outputs got rdy=%b req=%b to=%b sd=%b want 1 0 0 0", ex_ready, dmem_if.req, timeout, store_done); else pass_cnt++;
        tick();
        total_cnt++; if (wb_valid !== 1'b0) $display("FAIL rst_no_wb got %b want 0", wb_valid); else pass_cnt++;
    endtask

    initial begin
        pass_cnt       = 0;
        total_cnt      = 0;
        rst_n          = 1'b0;
        ex_valid       = 1'b0;
        ex_mem_read    = 1'b0;
        ex_mem_write   = 1'b0;
        ex_size        = 2'b00;
        ex_unsigned    = 1'b0;
        ex_addr        = '0;
        ex_store_data  = '0;
        ex_rd          = '0;
        dmem_if.gnt    = 1'b0;
        dmem_if.rvalid = 1'b0;
        dmem_if.rdata  = '0;
        #1;
        test_reset();
        test_ignore();
        test_lw();
        test_lb();
        test_store();
        test_misalign();
        test_stall();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
